// File: rtl/nibble_serial_comparator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nibble_serial_comparator
// Description : Serial magnitude comparator. Compares two W-bit operands
//               (W = 4*NIBBLES) one nibble per clock, LSB nibble first, using
//               a cascaded {eq,gt,lt} state. Optional two's-complement mode
//               flips the sign bit of the MSB nibble before its compare.
//               Latency is fixed: result valid NIBBLES edges after accept.
// Ports       : clk          - clock, rising edge
//               rst_n        - synchronous active-low reset
//               start_valid  - request operands valid
//               start_ready  - block can accept a request (IDLE)
//               a, b         - operands
//               is_signed    - 1 = two's-complement, 0 = unsigned compare
//               res_valid    - result valid (DONE)
//               res_ready    - consumer accepts result
//               res_eq/gt/lt - one-hot compare result (A==B, A>B, A<B)
//               busy         - request in flight or result held
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_comparator #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   is_signed,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_eq,
    output logic                   res_gt,
    output logic                   res_lt,
    output logic                   busy
);

    localparam int c_w     = 4 * NIBBLES;
    localparam int c_idx_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NIBBLES - 1);

    // Cascade encoding {eq, gt, lt}
    localparam logic [2:0] c_cas_eq = 3'b100;
    localparam logic [2:0] c_cas_gt = 3'b010;
    localparam logic [2:0] c_cas_lt = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_w-1:0]     a_q, a_d;
    logic [c_w-1:0]     b_q, b_d;
    logic               signed_q, signed_d;
    logic [c_idx_w-1:0] idx_q, idx_d;
    logic [2:0]         cas_q, cas_d;
    logic [2:0]         res_q, res_d;

    logic               w_last;
    logic               w_flip;
    logic [3:0]         w_nib_a;
    logic [3:0]         w_nib_b;
    logic [2:0]         w_cas_next;

    // Operands are shifted right one nibble per RUN cycle, so the nibble
    // under compare is always in bits [3:0].
    assign w_last  = (idx_q == c_last_idx);
    // Flipping bit 3 of both MSB nibbles maps two's-complement order onto
    // unsigned order for that nibble.
    assign w_flip  = signed_q & w_last;
    assign w_nib_a = a_q[3:0] ^ {w_flip, 3'b000};
    assign w_nib_b = b_q[3:0] ^ {w_flip, 3'b000};

    // A more significant nibble that differs overrides the lower decision;
    // equal nibbles carry the lower decision through.
    always_comb begin
        w_cas_next = cas_q;
        if (w_nib_a > w_nib_b) begin
            w_cas_next = c_cas_gt;
        end else if (w_nib_a < w_nib_b) begin
            w_cas_next = c_cas_lt;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        cas_d    = cas_q;
        res_d    = res_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_d      = a;
                    b_d      = b;
                    signed_d = is_signed;
                    idx_d    = '0;
                    cas_d    = c_cas_eq;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                cas_d = w_cas_next;
                if (w_last) begin
                    res_d   = w_cas_next;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                // start_valid deliberately ignored here, even with res_ready.
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            cas_q    <= c_cas_eq;
            res_q    <= 3'b000;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            cas_q    <= cas_d;
            res_q    <= res_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign res_eq      = res_q[2];
    assign res_gt      = res_q[1];
    assign res_lt      = res_q[0];

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_comparator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_comparator
// Description : Directed self-checking bench for nibble_serial_comparator
//               (NIBBLES=4). Each scenario task drives stimulus and checks
//               against hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_comparator;

    localparam int NIBBLES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        is_signed = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_eq;
    logic        res_gt;
    logic        res_lt;
    logic        busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    nibble_serial_comparator #(.NIBBLES(NIBBLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .is_signed   (is_signed),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_eq      (res_eq),
        .res_gt      (res_gt),
        .res_lt      (res_lt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble the inputs so any
    // dependence on live operands after capture shows up.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        a = av;
        b = bv;
        is_signed = sv;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        a = ~av;
        b = ~bv;
        is_signed = ~sv;
    endtask

    // Edges from now until res_valid rises (bounded).
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic retire();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b expected 0", res_valid);
        else pass_cnt++;
        chk_cnt++;
        if ({res_eq, res_gt, res_lt} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {res_eq, res_gt, res_lt});
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (start_ready !== 1'b1) $display("FAIL reset_start_ready: got %b expected 1", start_ready);
        else pass_cnt++;
    endtask

    // First request on the very first edge with rst_n=1; exact latency.
    task automatic test_first_unsigned_lt();
        int cyc;
        rst_n = 1'b1;
        issue(16'h0000, 16'h0002, 1'b0);
        chk_cnt++;
        if ({start_ready, busy} !== 2'b01) $display("FAIL accept_first: got ready,busy=%b expected 01", {start_ready, busy});
        else pass_cnt++;
        wait_result(cyc);
        chk_cnt++;
        if (cyc !== 4) $display("FAIL latency_first: got %0d expected 4", cyc);
        else pass_cnt++;
        chk_cnt++;
        if ({res_eq, res_gt, res_lt} !== 3'b001) $display("FAIL result_first: got %b expected 001", {res_eq, res_gt, res_lt});
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_done: got %b expected 1", busy);
        else pass_cnt++;
        retire();
        chk_cnt++;
        if ({res_valid, start_ready, busy} !== 3'b010) $display("FAIL idle_after_done: got valid,ready,busy=%b expected 010", {res_valid, start_ready, busy});
        else pass_cnt++;
        chk_cnt++;
        if ({res_eq, res_gt, res_lt} !== 3'b001) $display("FAIL result_kept_in_idle: got %b expected 001", {res_eq, res_gt, res_lt});
        else pass_cnt++;
    endtask

    task automatic test_compare_table();
        logic [15:0] ta [10] = '{16'h1234, 16'h1234, 16'h8000, 16'h8000, 16'hF0F1,
                                 16'hF0F1, 16'hFFFF, 16'hFFFF, 16'h1000, 16'h0FFF};
        logic [15:0] tb [10] = '{16'h1234, 16'h1234, 16'h7FFF, 16'h7FFF, 16'hF0F0,
                                 16'hF0F0, 16'h0001, 16'h0001, 16'h0FFF, 16'h1000};
        logic        ts [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  te [10] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b010,
                                 3'b010, 3'b001, 3'b010, 3'b010, 3'b001};
        int cyc;
        for (int i = 0; i < 10; i++) begin
            issue(ta[i], tb[i], ts[i]);
            wait_result(cyc);
            chk_cnt++;
            if (cyc !== 4) $display("FAIL latency_vec%0d: got %0d expected 4", i, cyc);
            else pass_cnt++;
            chk_cnt++;
            if ({res_eq, res_gt, res_lt} !== te[i])
                $display("FAIL result_vec%0d a=%h b=%h s=%b: got %b expected %b",
                         i, ta[i], tb[i], ts[i], {res_eq, res_gt, res_lt}, te[i]);
            else pass_cnt++;
            retire();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        issue(16'h00A0, 16'h00B0, 1'b0);
        wait_result(cyc);
        chk_cnt++;
        if (cyc !== 4) $display("FAIL latency_bp: got %0d expected 4", cyc);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            start_valid = i[0];
            a = 16'hFFFF;
            b = 16'h0000;
            tick();
            chk_cnt++;
            if ({res_valid, start_ready, busy} !== 3'b101)
                $display("FAIL bp_hold%0d: got valid,ready,busy=%b expected 101", i, {res_valid, start_ready, busy});
            else pass_cnt++;
            chk_cnt++;
            if ({res_eq, res_gt, res_lt} !== 3'b001)
                $display("FAIL bp_result%0d: got %b expected 001", i, {res_eq, res_gt, res_lt});
            else pass_cnt++;
        end
        // start_valid together with res_ready in DONE must not start a request.
        start_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        start_valid = 1'b0;
        res_ready = 1'b0;
        chk_cnt++;
        if ({res_valid, start_ready, busy} !== 3'b010)
            $display("FAIL bp_release: got valid,ready,busy=%b expected 010", {res_valid, start_ready, busy});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL bp_no_accept: got busy=%b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        issue(16'h1234, 16'h0000, 1'b0);
        tick();
        tick();
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL midrun_busy: got %b expected 1", busy);
        else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_cnt++;
        if ({res_valid, start_ready, busy} !== 3'b010)
            $display("FAIL midrun_reset_ctrl: got valid,ready,busy=%b expected 010", {res_valid, start_ready, busy});
        else pass_cnt++;
        chk_cnt++;
        if ({res_eq, res_gt, res_lt} !== 3'b000)
            $display("FAIL midrun_reset_flags: got %b expected 000", {res_eq, res_gt, res_lt});
        else pass_cnt++;
        issue(16'h0005, 16'h0003, 1'b0);
        wait_result(cyc);
        chk_cnt++;
        if (cyc !== 4) $display("FAIL latency_after_reset: got %0d expected 4", cyc);
        else pass_cnt++;
        chk_cnt++;
        if ({res_eq, res_gt, res_lt} !== 3'b010)
            $display("FAIL result_after_reset: got %b expected 010", {res_eq, res_gt, res_lt});
        else pass_cnt++;
        retire();
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [3] = '{16'h0003, 16'h7000, 16'h0001};
        logic [15:0] tb [3] = '{16'h0003, 16'h9000, 16'h0010};
        logic        ts [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  te [3] = '{3'b100, 3'b010, 3'b001};
        int cyc;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], ts[i]);
            wait_result(cyc);
            chk_cnt++;
            if (cyc !== 4) $display("FAIL latency_b2b%0d: got %0d expected 4", i, cyc);
            else pass_cnt++;
            chk_cnt++;
            if ({res_eq, res_gt, res_lt} !== te[i])
                $display("FAIL result_b2b%0d: got %b expected %b", i, {res_eq, res_gt, res_lt}, te[i]);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if ({res_valid, start_ready} !== 2'b01)
                $display("FAIL b2b_single_cycle%0d: got valid,ready=%b expected 01", i, {res_valid, start_ready});
            else pass_cnt++;
        end
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_unsigned_lt();
        test_compare_table();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_comparator.md
NIBBLE_SERIAL_COMPARATOR -- requirements
Module: nibble_serial_comparator

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port start_valid, input, 1 bit, meaning the request operands are valid.
REQ-005 The block SHALL have port start_ready, output, 1 bit, meaning the block can accept a request.
REQ-006 The block SHALL have port a, input, W bits, meaning operand A.
REQ-007 The block SHALL have port b, input, W bits, meaning operand B.
REQ-008 The block SHALL have port is_signed, input, 1 bit, meaning 1 = two's-complement compare and 0 = unsigned compare.
REQ-009 The block SHALL have port res_valid, output, 1 bit, meaning the result is valid.
REQ-010 The block SHALL have port res_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-011 The block SHALL have ports res_eq, res_gt, res_lt, each output, 1 bit, giving the one-hot result A==B, A>B, A<B.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a request is being processed or held.

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE SHALL drive start_ready=1, busy=0 and res_valid=0.
REQ-015 In IDLE, when start_valid=1, the block SHALL capture a, b and is_signed, load cascade {eq,gt,lt}={1,0,0}, set the nibble index to 0 and go to RUN.
REQ-016 RUN SHALL process one nibble per cycle, LSB nibble (index 0) first, as a cascaded 4-bit magnitude compare.
REQ-017 For each nibble, the block SHALL set cascade to gt if A_nib>B_nib, lt if A_nib<B_nib, and keep the cascade unchanged if the nibbles are equal.
REQ-018 For the MSB nibble (index NIBBLES-1) with the captured is_signed=1, the block SHALL invert bit 3 of both nibbles before the compare; all other nibbles SHALL compare unsigned.
REQ-019 After the nibble at index NIBBLES-1 is processed, the block SHALL register the final cascade into res_eq/res_gt/res_lt and go to DONE.
REQ-020 Latency SHALL be fixed: a request accepted on edge k SHALL give res_valid=1 after edge k+NIBBLES, with no early termination.
REQ-021 DONE SHALL hold res_valid=1 and the result stable until res_ready=1, then go to IDLE on that edge.
REQ-022 After leaving DONE, res_valid SHALL be 0 in IDLE while res_eq/gt/lt keep their last values.
REQ-023 start_ready SHALL be 0 in RUN and DONE, and start_valid SHALL be ignored in those states, including a simultaneous start_valid and res_ready in DONE.
REQ-024 Changes on a, b or is_signed after capture SHALL NOT affect an in-flight compare.
REQ-025 Exactly one of res_eq/res_gt/res_lt SHALL be 1 whenever res_valid=1.
REQ-026 busy SHALL be 1 in RUN and DONE.

Reset
REQ-027 rst_n=0 on a clock edge SHALL force IDLE from any state, including mid-RUN and DONE, and SHALL discard the in-flight request.
REQ-028 Reset SHALL drive res_valid=0, res_eq=0, res_gt=0, res_lt=0, busy=0, start_ready=1, nibble index 0 and cascade {1,0,0}.
REQ-029 The first request SHALL be accepted on the first edge with rst_n=1 and start_valid=1.

Verification
REQ-030 NIBBLES=4, unsigned, a=0x0000, b=0x0002 -> res_lt=1 exactly 4 cycles after accept.
REQ-031 a=0x1234, b=0x1234, either mode -> res_eq=1.
REQ-032 a=0x8000, b=0x7FFF -> res_gt=1 when is_signed=0 and res_lt=1 when is_signed=1.
REQ-033 a=0xF0F1, b=0xF0F0 -> res_gt=1, with the decision coming from the LSB nibble carried through the three equal nibbles.
REQ-034 res_ready held 0 for 10 cycles after res_valid -> result stable, start_ready=0, pulses on start_valid ignored; then res_ready=1 -> IDLE on the next edge.
REQ-035 rst_n=0 for one edge during RUN (index 2), then a new request a=0x0005, b=0x0003 -> outputs at reset values after the reset edge, then res_gt=1 after 4 cycles with no stale result.
